// File: rtl/mips_cpu_run_controller.sv
// Run controller and bus monitor for CPU bring-up: sequences CPU reset, runs until
// halt or cycle budget expiry, latches register_v0 and counts bus activity.
module mips_cpu_run_controller #(
    parameter int CYC_W        = 16,
    parameter int CNT_W        = 16,
    parameter int MAX_CYCLES   = 2000,
    parameter int RESET_CYCLES = 1,
    parameter int ACTIVE_GRACE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cpu_active,
    input  logic [31:0]      register_v0,
    input  logic             read,
    input  logic             write,
    input  logic             waitrequest,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             timed_out,
    output logic             bus_error,
    output logic [31:0]      result_v0,
    output logic [CYC_W-1:0] cycle_count,
    output logic [CNT_W-1:0] read_count,
    output logic [CNT_W-1:0] write_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [2:0] {IDLE, RST_SEQ, RUN, HALTED, TIMEOUT} state_t;

    localparam int               RST_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);
    localparam logic [CYC_W-1:0] GRACE    = CYC_W'(ACTIVE_GRACE);

    state_t           state_q, state_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic             bus_error_q, bus_error_d;
    logic [31:0]      result_q, result_d;
    logic [CYC_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] st_cnt_q, st_cnt_d;

    logic start_ok, in_run, halt_now, timeout_now;

    always_comb begin
        start_ok    = start && (state_q == IDLE || state_q == HALTED || state_q == TIMEOUT);
        in_run      = (state_q == RUN);
        halt_now    = in_run && !cpu_active && (cycle_q >= GRACE);
        timeout_now = in_run && (cycle_q == CYC_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rst_cnt_q   <= '0;
            bus_error_q <= 1'b0;
            result_q    <= '0;
            cycle_q     <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            st_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            bus_error_q <= bus_error_d;
            result_q    <= result_d;
            cycle_q     <= cycle_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            st_cnt_q    <= st_cnt_d;
        end
    end

    // Halt takes precedence over timeout when both fire in the same RUN cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HALTED, TIMEOUT: if (start_ok) state_d = RST_SEQ;
            RST_SEQ:               if (rst_cnt_q == RST_LAST) state_d = RUN;
            RUN: begin
                if (halt_now)         state_d = HALTED;
                else if (timeout_now) state_d = TIMEOUT;
            end
            default:               state_d = IDLE;
        endcase
    end

    always_comb begin
        rst_cnt_d   = rst_cnt_q;
        bus_error_d = bus_error_q;
        result_d    = result_q;
        cycle_d     = cycle_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        st_cnt_d    = st_cnt_q;
        if (start_ok) begin
            rst_cnt_d   = '0;
            bus_error_d = 1'b0;
            result_d    = '0;
            cycle_d     = '0;
            rd_cnt_d    = '0;
            wr_cnt_d    = '0;
            st_cnt_d    = '0;
        end else if (state_q == RST_SEQ) begin
            rst_cnt_d = (rst_cnt_q == RST_LAST) ? '0 : rst_cnt_q + RST_W'(1);
        end else if (in_run) begin
            // All counters saturate at all-ones rather than wrapping.
            if (cycle_q != '1) cycle_d = cycle_q + CYC_W'(1);
            if (read && !waitrequest && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
            if (write && !waitrequest && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
            if ((read || write) && waitrequest && st_cnt_q != '1) st_cnt_d = st_cnt_q + CNT_W'(1);
            if (read && write) bus_error_d = 1'b1;
            if (halt_now) result_d = register_v0;
        end
    end

    always_comb begin
        cpu_reset = (state_q != RUN);
        running   = (state_q == RUN);
        done      = (state_q == HALTED) || (state_q == TIMEOUT);
        timed_out = (state_q == TIMEOUT);
    end

    assign bus_error   = bus_error_q;
    assign result_v0   = result_q;
    assign cycle_count = cycle_q;
    assign read_count  = rd_cnt_q;
    assign write_count = wr_cnt_q;
    assign stall_count = st_cnt_q;

endmodule

// File: doc/mips_cpu_run_controller.md
Name: mips_cpu_run_controller

Overview:
- Synthesisable run controller and bus monitor for CPU bring-up. It generalises the hand-written pipeline bench harness: reset sequencing, cycle counting, halt detection and cycle budget.
- Sequences CPU reset, runs the CPU until `active` deasserts or a cycle budget expires, then latches `register_v0`.
- Counts accepted bus reads and writes and waitrequest stall cycles.
- Sits between the bench (or an FPGA debug host) and `mips_cpu_bus` / `mips_cpu_bus_pipeline` plus memory; repeated runs need no bench-level timing code.

Parameters:
- CYC_W, 16, width of cycle counter and of MAX_CYCLES.
- CNT_W, 16, width of read/write/stall counters.
- MAX_CYCLES, 2000, cycle budget in RUN before timeout; must be ≥ ACTIVE_GRACE+1.
- RESET_CYCLES, 1, cycles cpu_reset is held high in RST_SEQ; must be ≥1.
- ACTIVE_GRACE, 1, initial RUN cycles during which cpu_active=0 is ignored.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high controller reset.
- start, input, 1, begin a run; sampled only in IDLE, HALTED or TIMEOUT.
- cpu_active, input, 1, CPU `active` output.
- register_v0, input, 32, CPU `register_v0` output.
- read, input, 1, CPU bus read strobe.
- write, input, 1, CPU bus write strobe.
- waitrequest, input, 1, memory waitrequest.
- cpu_reset, output, 1, reset driven to the CPU.
- running, output, 1, high in RUN.
- done, output, 1, high in HALTED or TIMEOUT.
- timed_out, output, 1, high in TIMEOUT.
- bus_error, output, 1, sticky: read and write asserted together during RUN.
- result_v0, output, 32, register_v0 latched at halt.
- cycle_count, output, CYC_W, RUN cycles elapsed.
- read_count, output, CNT_W, accepted reads.
- write_count, output, CNT_W, accepted writes.
- stall_count, output, CNT_W, cycles with (read|write)&waitrequest.

Behaviour:
- Clock and reset: one clock, `clk`; `reset` is synchronous and active-high.
- Reset values: state IDLE, cpu_reset=1, running=0, done=0, timed_out=0, bus_error=0. result_v0, cycle_count and all counters =0.
- States: IDLE, RST_SEQ, RUN, HALTED, TIMEOUT.
- IDLE:
  - cpu_reset=1.
  - start=1 → RST_SEQ; clears all counters, result_v0 and bus_error on the same edge.
- RST_SEQ:
  - cpu_reset=1 for exactly RESET_CYCLES cycles (internal counter), then → RUN.
  - start ignored.
- RUN:
  - cpu_reset=0, running=1; cycle_count +1 every cycle, including the exiting cycle.
  - Halt: cpu_active=0 while cycle_count ≥ ACTIVE_GRACE → HALTED. result_v0 ← register_v0 sampled that same cycle.
  - Timeout: cycle_count = MAX_CYCLES-1 with no halt condition → TIMEOUT; result_v0 unchanged (0).
  - Halt and timeout in the same cycle: halt wins.
  - start ignored.
- Bus monitoring (RUN only):
  - read & !waitrequest → read_count+1.
  - write & !waitrequest → write_count+1.
  - (read|write) & waitrequest → stall_count+1.
  - read & write → bus_error=1 (sticky until next start or reset). In that cycle both read_count and write_count are counted per the rules above.
- Counter saturation: all counters saturate at all-ones and never wrap.
- HALTED / TIMEOUT:
  - done=1 (timed_out=1 in TIMEOUT only); cpu_reset=1 to freeze the CPU.
  - All counters and result_v0 held.
  - start=1 → RST_SEQ (restart, clears as in IDLE).
- Priority: reset overrides all. A reset in mid-RUN returns to IDLE with reset values on the next edge; no partial result is retained.
- Outputs are registered; done/timed_out rise one cycle after the terminating RUN cycle.
- Latencies:
  - start to first cpu_reset=0 cycle: RESET_CYCLES+1 edges.
  - Halt cycle to done=1: 1 edge.

Test Plan:
- Reset then start, CPU drops active at RUN cycle 40 with register_v0=0x0000_0007 → done=1, timed_out=0, result_v0=7, cycle_count=41, cpu_reset high 1 cycle after start.
- CPU never halts, MAX_CYCLES=2000 → TIMEOUT after 2000 RUN cycles, cycle_count=2000, timed_out=1, result_v0=0.
- cpu_active=0 in RUN cycle 0 with ACTIVE_GRACE=1 → ignored; active=0 at cycle 1 → HALTED, cycle_count=2.
- Memory inserts 2 waitrequest cycles on each of 5 reads and 3 writes → read_count=5, write_count=3, stall_count=16.
- read=write=1 for one RUN cycle → bus_error=1, held through HALTED; new start clears it and all counters.
- Reset asserted at RUN cycle 10 → next edge IDLE, cpu_reset=1, all counters 0; start during RUN or RST_SEQ has no effect. Halt and timeout in the same cycle → HALTED.
